lsp_prev_update: RTL and testbench
==================================

// Module: lsp_prev_update
// PURPOSE
// - G.729 Qua_Lsp MA-predictor history update: freq_prev[j][k] = freq_prev[j][k-1] for k=3..1, then freq_prev[j][0] = lsp_ele[j], for j=0..9.
// - Sits directly downstream of the LSP element extract/compose stage. It consumes lsp_ele[] from shared data memory and ages the 4-frame freq_prev history in place.
// - Sequential read/write engine on the shared single-read/single-write data memory; no arithmetic datapath.
// PARAMETERS
// - M       10  LSP order; j runs 0..M-1.
// - MA_NP    4  MA predictor order; k runs MA_NP-1..0.
// PORTS
// - clk        in   1   system clock, rising edge.
// - reset      in   1   asynchronous, active-low reset (asserted at 0).
// - start      in   1   begin update; sampled in IDLE only.
// - done       out  1   one-cycle pulse when the update is complete.
// - lspele     in  11   base address of lsp_ele[]; element addr = {lspele[10:4], j[3:0]}.
// - freq_prev  in  11   base address of freq_prev[][]; addr = {freq_prev[10:6], j[3:0], k[1:0]}.
// - readAddr   out 11   memory read address; data returns on readIn next cycle (1-cycle sync read).
// - readIn     in  32   memory read data; only [15:0] is used.
// - writeAddr  out 11   memory write address.
// - writeOut   out 32   write data = {16'h0000, word[15:0]}.
// - writeEn    out  1   write strobe, one word per cycle.
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, j=0, k=3, data register=0. done, writeEn, readAddr, writeAddr and writeOut are all 0.
// - All outputs are 0 in every cycle that does not drive them.
// - Element order: outer j 0..9, inner k 3,2,1,0.
//   - Source for k>0 is freq_prev[j][k-1]; source for k=0 is lsp_ele[j].
//   - Destination is freq_prev[j][k].
//   - Descending k guarantees each source is read before it is overwritten.
// - FSM, default build:
//   - IDLE: if start, go to RD.
//   - RD: readAddr = source(j,k); go to WR.
//   - WR: writeAddr = dest(j,k), writeOut = {16'h0, readIn[15:0]}, writeEn = 1. Then advance:
//     - k>0: k--.
//     - k=0: k=3, j++.
//     - j=9 and k=0: go to FIN; otherwise go to RD.
//   - FIN: done = 1, j=0, k=3; go to IDLE.
// - Latency, default build: 2 cycles per element, 40 elements. done is high in cycle 81 after the edge that samples start (cycle 1 = first RD).
// - start is ignored outside IDLE. If start is held high, a new update begins the cycle after FIN returns to IDLE.
// - Counters: j is 4 bits and terminates at 9; k is 2 bits with a 0 -> 3 wrap that increments j. Addresses never exceed j=9.
// - Data is copied bit-exact. No saturation, no sign handling; readIn[31:16] is discarded.
// - Reset mid-operation: aborts immediately and returns to IDLE. Memory is left partially shifted, with no rollback; the caller must restore or re-run.
// - Base-address inputs must be stable from start until done.
// CONFIGURATION
// - LSP_PREV_UPDATE_PIPE_EN defined: read and write overlap.
//   - Cycle 1 issues read(e0).
//   - Cycle n (2..40) writes e(n-2) from readIn and reads e(n-1).
//   - Cycle 41 writes e39.
//   - Cycle 42 is FIN with done = 1.
//   - Same-cycle read(j,k-1) / write(j,k) never alias, so no hazard exists.
//   - The memory must accept one read and one write in the same cycle.
// - LSP_PREV_UPDATE_PIPE_EN undefined: 2-cycle RD/WR FSM as above. readAddr and writeEn are never active in the same cycle.
// TESTING
// - Shift: preload freq_prev[j][k] = 16'h0100*k + j and lsp_ele[j] = 16'h0F00 + j, then pulse start. After done:
//   - freq_prev[j][3] = 0x0200+j, [2] = 0x0100+j, [1] = j, [0] = 0x0F00+j.
//   - done in cycle 81 (42 with PIPE_EN).
// - Write integrity: readIn[31:16] = 16'hFFFF on every read. Expect exactly 40 writeEn pulses, all writeOut[31:16] = 0, and 16'h8000 / 16'h7FFF copied unchanged.
// - Addressing: freq_prev = 11'h7C0, lspele = 11'h3F0. Expect all writes in 0x7C0..0x7E7, reads only there or in 0x3F0..0x3F9, and no write to any lspele address.
// - Handshake: start held high for 200 cycles. Expect two complete updates, each done exactly 1 cycle wide, and no start accepted mid-run.
// - Reset mid-op: drive reset=0 asynchronously at cycle 20. Outputs go to 0 before the next edge. Release, pulse start; a full update completes with done in cycle 81.

Source files
------------

// File: rtl/lsp_prev_update_if.sv
// Shared data-memory port plus start/done handshake for the freq_prev history update engine.
// master: the update engine; slave: the memory/controller side.
interface lsp_prev_update_if;
  logic        start;
  logic        done;
  logic [10:0] lspele;
  logic [10:0] freq_prev;
  logic [10:0] readAddr;
  logic [31:0] readIn;
  logic [10:0] writeAddr;
  logic [31:0] writeOut;
  logic        writeEn;

  modport master (
    input  start, lspele, freq_prev, readIn,
    output done, readAddr, writeAddr, writeOut, writeEn
  );

  modport slave (
    output start, lspele, freq_prev, readIn,
    input  done, readAddr, writeAddr, writeOut, writeEn
  );
endinterface

// File: rtl/lsp_prev_update.sv
// MA-predictor history update: freq_prev[j][k] <= freq_prev[j][k-1] (k=3..1), freq_prev[j][0] <= lsp_ele[j]; done in cycle 81
// (42 with LSP_PREV_UPDATE_PIPE_EN, overlapped read/write); no backpressure, memory must accept every access.
module lsp_prev_update #(
  parameter int M     = 10,
  parameter int MA_NP = 4
) (
  input  logic               clk,
  input  logic               reset,
  lsp_prev_update_if.master  bus
);

  localparam logic [3:0] J_LAST = 4'(M - 1);
  localparam logic [1:0] K_TOP  = 2'(MA_NP - 1);

`ifdef LSP_PREV_UPDATE_PIPE_EN
  typedef enum logic [2:0] {IDLE, RD0, RUN, WL, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
`endif

  state_t      state_q, state_d;
  logic [3:0]  j_q, j_d;
  logic [1:0]  k_q, k_d;
  logic [3:0]  nj;
  logic [1:0]  nk;

  logic        done_c;
  logic [10:0] rd_addr_c;
  logic [10:0] wr_addr_c;
  logic [31:0] wr_dat_c;
  logic        wr_en_c;

  // Low base bits are replaced by the j/k index; readIn upper half is discarded.
  logic unused_bits;
  assign unused_bits = ^{bus.lspele[3:0], bus.freq_prev[5:0], bus.readIn[31:16]};

  // Source of element (j,k): the previous history slot, or the new LSP for k=0.
  function automatic logic [10:0] src_addr(input logic [6:0] le_hi, input logic [4:0] fp_hi,
                                           input logic [3:0] j, input logic [1:0] k);
    if (k == 2'd0) return {le_hi, j};
    else           return {fp_hi, j, k - 2'd1};
  endfunction

  function automatic logic [10:0] dst_addr(input logic [4:0] fp_hi,
                                           input logic [3:0] j, input logic [1:0] k);
    return {fp_hi, j, k};
  endfunction

  assign nk = (k_q == 2'd0) ? K_TOP : k_q - 2'd1;
  assign nj = (k_q == 2'd0) ? j_q + 4'd1 : j_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      j_q     <= 4'd0;
      k_q     <= K_TOP;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    k_d       = k_q;
    done_c    = 1'b0;
    rd_addr_c = 11'd0;
    wr_addr_c = 11'd0;
    wr_dat_c  = 32'd0;
    wr_en_c   = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
`ifdef LSP_PREV_UPDATE_PIPE_EN
        state_d = RD0;
`else
        state_d = RD;
`endif
      end
`ifdef LSP_PREV_UPDATE_PIPE_EN
      RD0: begin
        rd_addr_c = src_addr(bus.lspele[10:4], bus.freq_prev[10:6], j_q, k_q);
        state_d   = RUN;
      end
      // Write (j,k) while reading the next element; read(j,k-1) never aliases write(j,k).
      RUN: begin
        wr_addr_c = dst_addr(bus.freq_prev[10:6], j_q, k_q);
        wr_dat_c  = {16'h0000, bus.readIn[15:0]};
        wr_en_c   = 1'b1;
        rd_addr_c = src_addr(bus.lspele[10:4], bus.freq_prev[10:6], nj, nk);
        j_d       = nj;
        k_d       = nk;
        if (nj == J_LAST && nk == 2'd0) state_d = WL;
      end
      WL: begin
        wr_addr_c = dst_addr(bus.freq_prev[10:6], j_q, k_q);
        wr_dat_c  = {16'h0000, bus.readIn[15:0]};
        wr_en_c   = 1'b1;
        state_d   = FIN;
      end
`else
      RD: begin
        rd_addr_c = src_addr(bus.lspele[10:4], bus.freq_prev[10:6], j_q, k_q);
        state_d   = WR;
      end
      WR: begin
        wr_addr_c = dst_addr(bus.freq_prev[10:6], j_q, k_q);
        wr_dat_c  = {16'h0000, bus.readIn[15:0]};
        wr_en_c   = 1'b1;
        if (j_q == J_LAST && k_q == 2'd0) begin
          state_d = FIN;
        end else begin
          j_d     = nj;
          k_d     = nk;
          state_d = RD;
        end
      end
`endif
      FIN: begin
        done_c  = 1'b1;
        j_d     = 4'd0;
        k_d     = K_TOP;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.done      = done_c;
  assign bus.readAddr  = rd_addr_c;
  assign bus.writeAddr = wr_addr_c;
  assign bus.writeOut  = wr_dat_c;
  assign bus.writeEn   = wr_en_c;

endmodule

// File: tb/tb_lsp_prev_update.sv
// Directed bench for lsp_prev_update: shift contents, write integrity, address ranges, start/done handshake, mid-run reset.
module tb_lsp_prev_update;

`ifdef LSP_PREV_UPDATE_PIPE_EN
  localparam int DONE_CYC = 42;
  localparam int OVL_EXP  = 39;
`else
  localparam int DONE_CYC = 81;
  localparam int OVL_EXP  = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsp_prev_update_if bus();
  lsp_prev_update dut (.clk(clk), .reset(reset), .bus(bus));

  logic [10:0] fp_base = 11'h400;
  logic [10:0] le_base = 11'h100;
  assign bus.freq_prev = fp_base;
  assign bus.lspele    = le_base;

  logic [15:0] mem [2048];
  logic        tb_we = 1'b0;
  logic [10:0] tb_addr = 11'd0;
  logic [15:0] tb_dat = 16'd0;

  // Sync-read memory; upper read half is all ones to prove it is dropped.
  always @(posedge clk) begin
    bus.readIn <= {16'hFFFF, mem[bus.readAddr]};
    if (bus.writeEn)  mem[bus.writeAddr] <= bus.writeOut[15:0];
    else if (tb_we)   mem[tb_addr] <= tb_dat;
  end

  int wr_cnt = 0, hi_err = 0, wr_rng_err = 0, wr_le_err = 0, rd_rng_err = 0, ovl_cnt = 0, done_wide = 0;
  logic done_prev = 1'b0;

  function automatic logic in_fp(input logic [10:0] a, input logic [10:0] b);
    return (a >= {b[10:6], 6'd0}) && (a <= {b[10:6], 6'd0} + 11'd39);
  endfunction
  function automatic logic in_le(input logic [10:0] a, input logic [10:0] b);
    return (a >= {b[10:4], 4'd0}) && (a <= {b[10:4], 4'd0} + 11'd9);
  endfunction

  always @(negedge clk) begin
    if (bus.writeEn) begin
      wr_cnt++;
      if (bus.writeOut[31:16] != 16'h0)         hi_err++;
      if (!in_fp(bus.writeAddr, fp_base))        wr_rng_err++;
      if (in_le(bus.writeAddr, le_base))         wr_le_err++;
    end
    if (bus.readAddr != 11'd0) begin
      if (!in_fp(bus.readAddr, fp_base) && !in_le(bus.readAddr, le_base)) rd_rng_err++;
      if (bus.writeEn) ovl_cnt++;
    end
    if (bus.done && done_prev) done_wide++;
    done_prev <= bus.done;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [10:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_dat = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  function automatic logic [10:0] fpa(input int j, input int k);
    logic [3:0] jj; logic [1:0] kk;
    jj = 4'(j); kk = 2'(k);
    return {fp_base[10:6], jj, kk};
  endfunction

  function automatic logic [10:0] lea(input int j);
    logic [3:0] jj;
    jj = 4'(j);
    return {le_base[10:4], jj};
  endfunction

  // Pulse start; returns the cycle (1 = first cycle after the sampling edge) in which done is seen.
  task automatic run_update(output int cyc);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, "_done"},  32'(bus.done),      32'd0);
    chk({pfx, "_wen"},   32'(bus.writeEn),   32'd0);
    chk({pfx, "_raddr"}, 32'(bus.readAddr),  32'd0);
    chk({pfx, "_waddr"}, 32'(bus.writeAddr), 32'd0);
    chk({pfx, "_wdat"},  bus.writeOut,       32'd0);
  endtask

  int cyc, w0, h0, r0, l0, rr0, o0, d0;
  int dcount, first_d, second_d, exp_cnt;

  initial begin
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    reset = 1'b1;

    // Shift pattern
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < 4; k++) poke(fpa(j, k), 16'(16'h0100 * k + j));
      poke(lea(j), 16'(16'h0F00 + j));
    end
    w0 = wr_cnt; d0 = done_wide;
    run_update(cyc);
    chk("shift_done_cycle", 32'(cyc), 32'(DONE_CYC));
    @(negedge clk);
    chk("shift_done_low_after", 32'(bus.done), 32'd0);
    chk("shift_writes", 32'(wr_cnt - w0), 32'd40);
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("fp[%0d][3]", j), 32'(mem[fpa(j, 3)]), 32'(16'h0200 + j));
      chk($sformatf("fp[%0d][2]", j), 32'(mem[fpa(j, 2)]), 32'(16'h0100 + j));
      chk($sformatf("fp[%0d][1]", j), 32'(mem[fpa(j, 1)]), 32'(j));
      chk($sformatf("fp[%0d][0]", j), 32'(mem[fpa(j, 0)]), 32'(16'h0F00 + j));
    end
    chk("le[9]_untouched", 32'(mem[lea(9)]), 32'h0F09);

    // Integrity and addressing at the top of the address map
    fp_base = 11'h7C0;
    le_base = 11'h3F0;
    poke(lea(0), 16'h8000);
    poke(fpa(0, 0), 16'h1234);
    poke(fpa(1, 0), 16'h7FFF);
    poke(fpa(9, 2), 16'hBEEF);
    w0 = wr_cnt; h0 = hi_err; r0 = wr_rng_err; l0 = wr_le_err; rr0 = rd_rng_err; o0 = ovl_cnt;
    run_update(cyc);
    chk("int_done_cycle", 32'(cyc), 32'(DONE_CYC));
    chk("int_writes", 32'(wr_cnt - w0), 32'd40);
    chk("int_hi_zero", 32'(hi_err - h0), 32'd0);
    chk("int_8000", 32'(mem[fpa(0, 0)]), 32'h8000);
    chk("int_1234", 32'(mem[fpa(0, 1)]), 32'h1234);
    chk("int_7fff", 32'(mem[fpa(1, 1)]), 32'h7FFF);
    chk("int_beef", 32'(mem[fpa(9, 3)]), 32'hBEEF);
    chk("addr_wr_range", 32'(wr_rng_err - r0), 32'd0);
    chk("addr_wr_lspele", 32'(wr_le_err - l0), 32'd0);
    chk("addr_rd_range", 32'(rd_rng_err - rr0), 32'd0);
    chk("rd_wr_overlap", 32'(ovl_cnt - o0), 32'(OVL_EXP));

    // Start held high for 200 cycles
    exp_cnt = 0;
    for (int c = DONE_CYC; c <= 200; c += DONE_CYC + 1) exp_cnt++;
    dcount = 0; first_d = 0; second_d = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.done) begin
        dcount++;
        if (dcount == 1) first_d = c;
        if (dcount == 2) second_d = c;
      end
    end
    bus.start = 1'b0;
    repeat (DONE_CYC + 5) @(negedge clk);
    chk("hs_done_count", 32'(dcount), 32'(exp_cnt));
    chk("hs_first_done", 32'(first_d), 32'(DONE_CYC));
    chk("hs_second_done", 32'(second_d), 32'(2 * DONE_CYC + 1));
    chk("hs_done_width", 32'(done_wide - d0), 32'd0);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_idle_outputs("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    w0 = wr_cnt;
    run_update(cyc);
    chk("rerun_done_cycle", 32'(cyc), 32'(DONE_CYC));
    chk("rerun_writes", 32'(wr_cnt - w0), 32'd40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
